// File: rtl/nios_pio_in_edge.sv
// Avalon-MM input PIO: per-bit synchroniser, optional debounce, edge capture
// with write-1-to-clear, interrupt mask and level/edge interrupt source.
module nios_pio_in_edge #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0,
    parameter int IRQ_TYPE        = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] in_port
);
    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] db_q, db_d;
    logic [WIDTH-1:0] db_prev_q, db_prev_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] rise, fall, edge_det, clr;
    logic             wr_en;
    logic             unused_inputs;

    assign wr_en = chipselect && !write_n;

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
            assign db_d = s2_q;
        end else begin : g_debounce
            localparam int PW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
            localparam logic [PW-1:0] PRE_LAST = PW'(DEBOUNCE_CYCLES - 1);

            logic [PW-1:0]    pre_q, pre_d;
            logic [WIDTH-1:0] sample_q, sample_d;
            logic [WIDTH-1:0] agree;
            logic             tick;

            // A bit is accepted only when two consecutive ticks see the same level
            always_comb begin
                tick     = (pre_q == PRE_LAST);
                pre_d    = tick ? '0 : pre_q + 1'b1;
                agree    = ~(s2_q ^ sample_q);
                sample_d = tick ? s2_q : sample_q;
                db_d     = tick ? ((db_q & ~agree) | (s2_q & agree)) : db_q;
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    pre_q    <= '0;
                    sample_q <= '0;
                end else begin
                    pre_q    <= pre_d;
                    sample_q <= sample_d;
                end
            end
        end
    endgenerate

    always_comb begin
        s1_d      = in_port;
        s2_d      = s1_q;
        db_prev_d = db_q;
        rise      = db_q & ~db_prev_q;
        fall      = ~db_q & db_prev_q;
        if (EDGE_TYPE == 0) begin
            edge_det = rise;
        end else if (EDGE_TYPE == 1) begin
            edge_det = fall;
        end else begin
            edge_det = rise | fall;
        end
        clr = (wr_en && address == 3'd3) ? writedata[WIDTH-1:0] : '0;
        // A new edge wins over a simultaneous clear of the same bit
        edge_capture_d = (edge_capture_q & ~clr) | edge_det;
        irq_mask_d     = (wr_en && address == 3'd2) ? writedata[WIDTH-1:0] : irq_mask_q;
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            3'd0:    readdata_d[WIDTH-1:0] = db_q;
            3'd2:    readdata_d[WIDTH-1:0] = irq_mask_q;
            3'd3:    readdata_d[WIDTH-1:0] = edge_capture_q;
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q           <= '0;
            s2_q           <= '0;
            db_q           <= '0;
            db_prev_q      <= '0;
            irq_mask_q     <= '0;
            edge_capture_q <= '0;
            readdata_q     <= '0;
        end else begin
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            db_q           <= db_d;
            db_prev_q      <= db_prev_d;
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
            readdata_q     <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq = (IRQ_TYPE == 0) ? |(db_q & irq_mask_q) : |(edge_capture_q & irq_mask_q);

    assign unused_inputs = ^{writedata, rise, fall};

endmodule

// File: tb/tb_nios_pio_in_edge.sv
// Directed bench for nios_pio_in_edge: four instances cover rising/any-edge
// capture, debounce and level interrupts on a shared Avalon bus.
module tb_nios_pio_in_edge;
    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_a, in_b, in_c, in_d;
    logic [31:0] rd_a, rd_b, rd_c, rd_d;
    logic        irq_a, irq_b, irq_c, irq_d;
    int          n_checks;
    int          n_fail;

    // a: rising/edge irq, b: any edge, c: debounce 4, d: level irq
    nios_pio_in_edge #(.WIDTH(8), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0), .IRQ_TYPE(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_a), .irq(irq_a), .in_port(in_a));
    nios_pio_in_edge #(.WIDTH(8), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2), .IRQ_TYPE(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_b), .irq(irq_b), .in_port(in_b));
    nios_pio_in_edge #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0), .IRQ_TYPE(0)) dut_c (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_c), .irq(irq_c), .in_port(in_c));
    nios_pio_in_edge #(.WIDTH(8), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0), .IRQ_TYPE(0)) dut_d (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_d), .irq(irq_d), .in_port(in_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_a       = 8'hFF;
        in_b       = 8'h00;
        in_c       = 8'h00;
        in_d       = 8'h00;

        // Reset with inputs high, then release
        wait_cycles(2);
        check("reset_rd_a", rd_a, 32'h0);
        check("reset_irq_a", {31'b0, irq_a}, 32'h0);
        check("reset_rd_c", rd_c, 32'h0);
        reset_n = 1'b1;
        address = 3'd3;
        wait_cycles(6);
        check("post_reset_edges", rd_a, 32'h0000_00FF);
        check("irq_masked", {31'b0, irq_a}, 32'h0);
        address = 3'd0;
        wait_cycles(1);
        check("db_read", rd_a, 32'h0000_00FF);

        // Rising edge capture, irq latency, W1C, falling ignored
        bus_write(3'd3, 32'hFF);
        bus_write(3'd2, 32'h01);
        in_a = 8'h00;
        wait_cycles(5);
        address = 3'd3;
        wait_cycles(1);
        check("fall_ignored", rd_a, 32'h0);
        in_a = 8'h01;
        wait_cycles(3);
        check("irq_before_k3", {31'b0, irq_a}, 32'h0);
        wait_cycles(1);
        check("irq_at_k3", {31'b0, irq_a}, 32'h1);
        wait_cycles(1);
        check("ec_bit0", rd_a, 32'h01);
        bus_write(3'd3, 32'h01);
        check("irq_cleared", {31'b0, irq_a}, 32'h0);
        in_a = 8'h00;
        wait_cycles(5);
        check("irq_after_fall", {31'b0, irq_a}, 32'h0);
        check("ec_after_fall", rd_a, 32'h0);

        // Any-edge capture and set-beats-clear
        in_b = 8'h08;
        wait_cycles(5);
        check("b_rise", rd_b, 32'h08);
        bus_write(3'd3, 32'h08);
        wait_cycles(1);
        check("b_clear1", rd_b, 32'h0);
        in_b = 8'h00;
        wait_cycles(5);
        check("b_fall", rd_b, 32'h08);
        bus_write(3'd3, 32'h08);
        wait_cycles(1);
        check("b_clear2", rd_b, 32'h0);
        in_b = 8'h08;
        wait_cycles(3);
        bus_write(3'd3, 32'h08);
        wait_cycles(1);
        check("b_set_wins", rd_b, 32'h08);

        // Debounce: short glitch rejected, held level accepted within two ticks
        address = 3'd0;
        in_c = 8'h02;
        wait_cycles(3);
        in_c = 8'h00;
        wait_cycles(12);
        check("c_glitch_db", rd_c, 32'h0);
        address = 3'd3;
        wait_cycles(1);
        check("c_glitch_ec", rd_c, 32'h0);
        address = 3'd0;
        in_c = 8'h02;
        wait_cycles(5);
        check("c_db_not_early", rd_c, 32'h0);
        wait_cycles(6);
        check("c_db_accepted", rd_c, 32'h02);

        // Level interrupt follows db, not edge_capture
        bus_write(3'd2, 32'h80);
        in_d = 8'h80;
        wait_cycles(2);
        check("d_irq_early", {31'b0, irq_d}, 32'h0);
        wait_cycles(1);
        check("d_irq_set", {31'b0, irq_d}, 32'h1);
        wait_cycles(3);
        check("d_irq_held", {31'b0, irq_d}, 32'h1);
        check("a_irq_mask80", {31'b0, irq_a}, 32'h0);
        in_d = 8'h00;
        wait_cycles(2);
        check("d_irq_lag", {31'b0, irq_d}, 32'h1);
        wait_cycles(1);
        check("d_irq_drop", {31'b0, irq_d}, 32'h0);
        address = 3'd3;
        wait_cycles(1);
        check("d_ec_kept", rd_d, 32'h80);

        // Unused addresses, ignored write, async reset
        in_a = 8'hFF;
        wait_cycles(5);
        address = 3'd1;
        wait_cycles(1);
        check("rd_addr1", rd_a, 32'h0);
        address = 3'd4;
        wait_cycles(1);
        check("rd_addr4", rd_a, 32'h0);
        address = 3'd7;
        wait_cycles(1);
        check("rd_addr7", rd_a, 32'h0);
        bus_write(3'd0, 32'hFFFF_FFFF);
        address = 3'd2;
        wait_cycles(1);
        check("mask_after_wr0", rd_a, 32'h80);
        address = 3'd3;
        wait_cycles(1);
        check("ec_after_wr0", rd_a, 32'hFF);
        bus_write(3'd3, 32'hA5);
        wait_cycles(1);
        check("ec_5a", rd_a, 32'h5A);
        bus_write(3'd2, 32'h5A);
        check("irq_5a", {31'b0, irq_a}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_irq", {31'b0, irq_a}, 32'h0);
        check("async_rd", rd_a, 32'h0);
        @(negedge clk);
        address = 3'd2;
        reset_n = 1'b1;
        wait_cycles(1);
        check("mask_cleared", rd_a, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
